// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin arbiter sequencing single-port data memory accesses
module data_memory_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ready0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              busy,
  output logic [DATA_W-1:0] Mem_address,
  output logic              Mem_read,
  output logic              Mem_write,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_Data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Upper bound for the unsigned address check, sized to the full address width.
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(MEM_DEPTH);

  state_t            state;
  logic              gnt;
  logic              prio;
  logic              lat_we;
  logic              lat_err;

  logic              elig0;
  logic              elig1;
  logic              grant_any;
  logic              grant_port;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

  // Round-robin grant decision; the port finishing in DONE sits out one cycle.
  always_comb begin
    elig0      = req0 && !((state == DONE) && (gnt == 1'b0));
    elig1      = req1 && !((state == DONE) && (gnt == 1'b1));
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if (state != ACCESS) begin
      if (elig0 && elig1) begin
        grant_any  = 1'b1;
        grant_port = prio;
      end else if (elig0) begin
        grant_any  = 1'b1;
        grant_port = 1'b0;
      end else if (elig1) begin
        grant_any  = 1'b1;
        grant_port = 1'b1;
      end
    end
    sel_we       = grant_port ? we1    : we0;
    sel_addr     = grant_port ? addr1  : addr0;
    sel_wdata    = grant_port ? wdata1 : wdata0;
    sel_in_range = (sel_addr < DEPTH_W);
  end

  // Sequencer: arbitrate in IDLE/DONE, drive one memory cycle in ACCESS, report in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      prio        <= 1'b0;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      ready0      <= 1'b0;
      ready1      <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      busy        <= 1'b0;
      Mem_address <= '0;
      Mem_read    <= 1'b0;
      Mem_write   <= 1'b0;
      Write_data  <= '0;
    end else begin
      ready0 <= 1'b0;
      ready1 <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      case (state)
        ACCESS: begin
          // Close the memory cycle and present the completion for the served port.
          Mem_read  <= 1'b0;
          Mem_write <= 1'b0;
          state     <= DONE;
          busy      <= 1'b1;
          if (gnt) begin
            ready1 <= 1'b1;
            err1   <= lat_err;
            if (!lat_err && !lat_we) begin
              rdata1 <= Read_Data;
            end
          end else begin
            ready0 <= 1'b1;
            err0   <= lat_err;
            if (!lat_err && !lat_we) begin
              rdata0 <= Read_Data;
            end
          end
        end
        default: begin
          // IDLE and DONE both arbitrate; an out-of-range grant leaves the memory port untouched.
          if (grant_any) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            gnt       <= grant_port;
            prio      <= ~grant_port;
            lat_we    <= sel_we;
            lat_err   <= ~sel_in_range;
            Mem_read  <= sel_in_range && !sel_we;
            Mem_write <= sel_in_range && sel_we;
            if (sel_in_range) begin
              Mem_address <= sel_addr;
              if (sel_we) begin
                Write_data <= sel_wdata;
              end
            end
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            Mem_read  <= 1'b0;
            Mem_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ready0, ready1, err0, err1, busy;
  logic [31:0] rdata0, rdata1;
  logic [31:0] Mem_address, Write_data, Read_Data;
  logic        Mem_read, Mem_write;

  logic [31:0] mem [32];
  int          vectors = 0;
  int          miscompares = 0;

  data_memory_arbiter #(.DATA_W(32), .MEM_DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ready0(ready0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ready1(ready1), .rdata1(rdata1), .err1(err1),
    .busy(busy), .Mem_address(Mem_address), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .Write_data(Write_data), .Read_Data(Read_Data)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write committed on the falling edge.
  assign Read_Data = mem[Mem_address[4:0]];
  always @(negedge clk) begin
    if (Mem_write) mem[Mem_address[4:0]] <= Write_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tick; tick;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ready0", ready0, 0);
    check("rst_ready1", ready1, 0);
    check("rst_mem_read", Mem_read, 0);
    check("rst_mem_write", Mem_write, 0);
    check("rst_mem_address", Mem_address, 0);
    check("rst_write_data", Write_data, 0);
    check("rst_rdata0", rdata0, 0);
    reset = 1'b0;
    tick;

    // Port 0 writes DEADBEEF to address 5
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hDEADBEEF;
    tick;
    check("wr_access_mem_write", Mem_write, 1);
    check("wr_access_mem_read", Mem_read, 0);
    check("wr_access_addr", Mem_address, 5);
    check("wr_access_wdata", Write_data, 32'hDEADBEEF);
    check("wr_access_busy", busy, 1);
    check("wr_access_ready0", ready0, 0);
    tick;
    check("wr_done_ready0", ready0, 1);
    check("wr_done_err0", err0, 0);
    check("wr_done_mem_write", Mem_write, 0);
    check("wr_done_busy", busy, 1);
    check("wr_mem_committed", mem[5], 32'hDEADBEEF);
    tick;
    req0 = 0;
    check("wr_idle_busy", busy, 0);
    check("wr_idle_ready0", ready0, 0);
    check("wr_idle_mem_write", Mem_write, 0);
    tick;

    // Port 0 reads address 5 back
    req0 = 1; we0 = 0; addr0 = 5;
    tick;
    check("rd_access_mem_read", Mem_read, 1);
    check("rd_access_addr", Mem_address, 5);
    check("rd_access_ready0", ready0, 0);
    tick;
    check("rd_done_ready0", ready0, 1);
    check("rd_done_rdata0", rdata0, 32'hDEADBEEF);
    check("rd_done_err0", err0, 0);
    check("rd_done_mem_read", Mem_read, 0);
    tick;
    req0 = 0;
    check("rd_idle_ready0", ready0, 0);
    check("rd_hold_rdata0", rdata0, 32'hDEADBEEF);

    // Fresh reset, then simultaneous reads: port 0 first, then port 1
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    tick;
    check("sim_acc0_mem_read", Mem_read, 1);
    check("sim_acc0_addr", Mem_address, 1);
    tick;
    check("sim_done0_ready0", ready0, 1);
    check("sim_done0_ready1", ready1, 0);
    check("sim_done0_rdata0", rdata0, 32'h1000_0001);
    check("sim_done0_mem_read", Mem_read, 0);
    tick;
    req0 = 0;
    check("sim_acc1_mem_read", Mem_read, 1);
    check("sim_acc1_addr", Mem_address, 2);
    check("sim_acc1_ready0", ready0, 0);
    tick;
    check("sim_done1_ready1", ready1, 1);
    check("sim_done1_ready0", ready0, 0);
    check("sim_done1_rdata1", rdata1, 32'h1000_0002);
    tick;
    req1 = 0;
    check("sim_idle_busy", busy, 0);

    // Continuous requests on both ports: strict alternation 0,1,0,1,...
    req0 = 1; we0 = 0; addr0 = 3;
    req1 = 1; we1 = 0; addr1 = 4;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 7) req0 = 0;
      check($sformatf("rr%0d_access_busy", k), busy, 1);
      check($sformatf("rr%0d_access_addr", k), Mem_address, (k % 2 == 0) ? 32'd3 : 32'd4);
      check($sformatf("rr%0d_access_mem_read", k), Mem_read, 1);
      tick;
      check($sformatf("rr%0d_done_busy", k), busy, 1);
      check($sformatf("rr%0d_done_ready0", k), ready0, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_done_ready1", k), ready1, (k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_done_rdata", k), (k % 2 == 0) ? rdata0 : rdata1,
            (k % 2 == 0) ? 32'h1000_0003 : 32'h1000_0004);
    end
    tick;
    req1 = 0;
    check("rr_end_busy", busy, 0);

    // Port 1 write to address 32 is rejected
    req1 = 1; we1 = 1; addr1 = 32; wdata1 = 32'h1234_5678;
    tick;
    check("oor_access_mem_write", Mem_write, 0);
    check("oor_access_mem_read", Mem_read, 0);
    check("oor_access_busy", busy, 1);
    tick;
    check("oor_done_ready1", ready1, 1);
    check("oor_done_err1", err1, 1);
    check("oor_done_mem_write", Mem_write, 0);
    check("oor_done_rdata1", rdata1, 32'h1000_0004);
    tick;
    req1 = 0;
    check("oor_idle_err1", err1, 0);
    check("oor_mem0_untouched", mem[0], 32'h1000_0000);
    tick;

    // Port 1 readback of address 0
    req1 = 1; we1 = 0; addr1 = 0;
    tick; tick;
    check("oor_rb_ready1", ready1, 1);
    check("oor_rb_err1", err1, 0);
    check("oor_rb_rdata1", rdata1, 32'h1000_0000);
    tick;
    req1 = 0;

    // Port 0 read of 0xFFFFFFFF is out of range
    req0 = 1; we0 = 0; addr0 = 32'hFFFF_FFFF;
    tick;
    check("max_access_mem_read", Mem_read, 0);
    tick;
    check("max_done_ready0", ready0, 1);
    check("max_done_err0", err0, 1);
    check("max_done_rdata0", rdata0, 32'h1000_0003);
    tick;
    req0 = 0;
    tick;

    // Reset in the middle of a port 0 ACCESS
    req0 = 1; we0 = 0; addr0 = 5;
    tick;
    check("mid_access_mem_read", Mem_read, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_read", Mem_read, 0);
    check("mid_rst_mem_address", Mem_address, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdata0", rdata0, 0);
    check("mid_rst_rdata1", rdata1, 0);
    check("mid_rst_write_data", Write_data, 0);
    check("mid_rst_ready0", ready0, 0);
    check("mid_rst_prio", dut.prio, 0);
    req0 = 0;
    tick;
    reset = 1'b0;
    tick;
    check("post_rst_ready0", ready0, 0);
    check("post_rst_busy", busy, 0);
    req0 = 1; we0 = 0; addr0 = 5;
    tick;
    check("post_rst_access_read", Mem_read, 1);
    tick;
    check("post_rst_done_ready0", ready0, 1);
    check("post_rst_done_rdata0", rdata0, 32'hDEADBEEF);
    tick;
    req0 = 0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Sequences every access to the data memory and shares its single port between two requesters: port 0 (CPU MEM stage) and port 1 (DMA/program loader). It accepts a held request/ready handshake on each port, grants one port at a time round-robin, and drives the memory's address/read/write/data strobes for exactly one access cycle. It returns read data registered with a one-cycle `ready` pulse. Out-of-range addresses are rejected without touching memory.

## Interface
- `DATA_W`, 32, data and address width.
- `MEM_DEPTH`, 32, number of memory words; valid addresses are 0..MEM_DEPTH-1.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  port request; held high until that port's `ready`.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while the port's `req` is high.
- `addr0`, `addr1`  in  DATA_W  word address; stable while the port's `req` is high.
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while the port's `req` is high.
- `ready0`, `ready1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_W  registered read data; valid while the port's `ready` is high, held until that port's next read completes.
- `err0`, `err1`  out  1  pulses with `ready` when the address is out of range.
- `busy`  out  1  high in ACCESS and DONE.
- `Mem_address`  out  DATA_W  memory address.
- `Mem_read`  out  1  memory read strobe.
- `Mem_write`  out  1  memory write strobe.
- `Write_data`  out  DATA_W  memory write data.
- `Read_Data`  in  DATA_W  memory read data; updates combinationally after the rising edge of `Mem_read`.

## Operation
- FSM states: IDLE, ACCESS, DONE. Registers: `gnt` (served port) and `prio` (preferred port).
- Arbitration happens in IDLE and in DONE:
  - If only one eligible port is requesting, grant it.
  - If both are requesting, grant `prio`.
  - On every grant, set `prio` to the non-granted port.
  - In DONE, the port just served is not eligible; its `req` is ignored that cycle.
- IDLE -> ACCESS on a grant; otherwise stay in IDLE. Latch the granted port's `we`, `addr` and `wdata` into internal registers.
- ACCESS, in-range address:
  - `Mem_address` = latched address.
  - Write: `Mem_write` = 1; memory commits on the negedge inside this cycle.
  - Read: `Mem_read` = 1.
  - At the closing posedge, capture `Read_Data` into `rdata[gnt]` (reads only). Go to DONE.
- ACCESS, out-of-range address (address >= MEM_DEPTH):
  - `Mem_read` and `Mem_write` stay 0.
  - `rdata[gnt]` is not updated.
  - Set the error flag. Go to DONE.
- DONE:
  - `ready[gnt]` = 1; `err[gnt]` = error flag.
  - Go to ACCESS on a new grant (the other port), else go to IDLE.
- `Mem_read` and `Mem_write` are 0 in IDLE and DONE. Every read therefore sees a fresh rising edge of `Mem_read`.
- `Mem_address` and `Write_data` hold their last values outside ACCESS.
- Both strobes are never high together. At most one `ready` is high per cycle.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS):
  - State = IDLE, `prio` = 0, `gnt` = 0.
  - All outputs are 0: `ready*`, `err*`, `busy`, `Mem_*`, `Write_data`, `rdata*`.
  - An access interrupted by reset is abandoned. No `ready` is issued; the requester must re-request.
- Latency: `req` sampled high at posedge N -> ACCESS in cycle N+1 -> `ready` in cycle N+2.
- Minimum request-to-ready latency is 2 cycles.
- Back-to-back alternating ports: one access every 2 cycles (ACCESS, DONE, ACCESS, ...).
- The same port re-requesting passes through IDLE, giving a 3-cycle period.
- A requester drops `req` in the cycle after `ready` at the earliest. `req` sampled in that cycle's IDLE counts as a new request.
- Simultaneous `req0` and `req1` in IDLE after reset: port 0 is served first, then port 1 is served starting in the DONE cycle.
- Address compare is unsigned over the full DATA_W bits. Address 0xFFFF_FFFF is out of range.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to address 5, then reads address 5: `Mem_write` high for exactly 1 cycle; `ready0` 2 cycles after each request; `rdata0` = 0xDEADBEEF; `err0` = 0.
- `req0` and `req1` asserted in the same cycle (reads of addresses 1 and 2): grant order 0 then 1; `ready0` in cycle N+2, `ready1` in cycle N+4; `Mem_read` low in the DONE cycle between the two reads.
- Both ports request continuously for 8 accesses: grants strictly alternate 0,1,0,1,...; `busy` stays high throughout; `ready0` and `ready1` are never high together.
- Port 1 writes to address 32 with MEM_DEPTH = 32: `Mem_write` never asserted; `ready1` and `err1` pulse together; memory contents unchanged on readback.
- `reset` asserted in the middle of a port 0 ACCESS cycle: all outputs are 0 immediately; no `ready0`; `prio` = 0; a fresh request completes normally.
